trap_sequencer: RTL and testbench

- Machine-mode trap controller sitting between the pipeline commit stage and the CSR file.
- Decides when a pending interrupt, a committed exception, or an mret is taken, and drives the CSR's intr_en/excep_en/mret/cause/pc inputs.
- Sequences pipeline stall, flush and PC redirect so that every trap lands on a precise instruction boundary.

---
 rtl/trap_pkg.sv | 24 ++
 rtl/trap_sequencer_if.sv | 44 ++++
 rtl/irq_prio.sv | 27 ++
 rtl/trap_sequencer.sv | 141 ++++++++++++++
 tb/tb_trap_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer and the CSR file:
// sequencer states, interrupt cause codes and CSR addresses.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    TAKE_INT = 3'd2,
    TAKE_EXC = 3'd3,
    RET      = 3'd4,
    RECOVER  = 3'd5
  } trap_state_e;

  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

endpackage

// File: rtl/trap_sequencer_if.sv
// Commit-stage, CSR and pipeline-control signals of the trap sequencer.
// No valid/ready pairs: commit_valid qualifies the commit fields each cycle,
// and intr_en/excep_en/mret are single-cycle pulses the CSR file acts on at once.
interface trap_sequencer_if #(
  parameter int XLEN = 32
);
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] fetch_pc;
  logic            excep_req;
  logic [3:0]      excep_code;
  logic            mret_req;
  logic            mie;
  logic            meie;
  logic            mtie;
  logic            meip;
  logic            mtip;

  logic            intr_en;
  logic            excep_en;
  logic            mret;
  logic [3:0]      intr_cause;
  logic [3:0]      exception_cause;
  logic [XLEN-1:0] trap_pc;
  logic            stall;
  logic            flush;
  logic            redirect;
  logic            redirect_sel;
  logic            busy;

  modport master (
    output commit_valid, commit_pc, fetch_pc, excep_req, excep_code, mret_req,
    output mie, meie, mtie, meip, mtip,
    input  intr_en, excep_en, mret, intr_cause, exception_cause, trap_pc,
    input  stall, flush, redirect, redirect_sel, busy
  );

  modport slave (
    input  commit_valid, commit_pc, fetch_pc, excep_req, excep_code, mret_req,
    input  mie, meie, mtie, meip, mtip,
    output intr_en, excep_en, mret, intr_cause, exception_cause, trap_pc,
    output stall, flush, redirect, redirect_sel, busy
  );
endinterface

// File: rtl/irq_prio.sv
// Combinational interrupt pending detect and priority encode:
// machine external beats machine timer.
module irq_prio
  import trap_pkg::*;
(
  input  logic       mie_i,
  input  logic       meie_i,
  input  logic       mtie_i,
  input  logic       meip_i,
  input  logic       mtip_i,
  output logic       irq_pend_o,
  output logic [3:0] intr_cause_o
);

  logic ext_hit;
  logic tmr_hit;

  always_comb begin
    ext_hit      = meip_i & meie_i;
    tmr_hit      = mtip_i & mtie_i;
    irq_pend_o   = mie_i & (ext_hit | tmr_hit);
    intr_cause_o = 4'd0;
    if (ext_hit)      intr_cause_o = CAUSE_MEI;
    else if (tmr_hit) intr_cause_o = CAUSE_MTI;
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: picks interrupt/exception/mret at a precise
// commit boundary and drives CSR strobes plus stall/flush/redirect.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int DRAIN_MAX = 8,
  parameter int XLEN      = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  trap_sequencer_if.slave bus,
  output trap_state_e     dbg_state_o
);

  localparam int CW = $clog2(DRAIN_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_MAX - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DRAIN_MAX);

  trap_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      exc_cause_q, exc_cause_d;
  logic [3:0]      intr_cause_q, intr_cause_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;

  logic       irq_pend;
  logic [3:0] irq_cause;
  logic       exc_hit;

  irq_prio u_irq_prio (
    .mie_i        (bus.mie),
    .meie_i       (bus.meie),
    .mtie_i       (bus.mtie),
    .meip_i       (bus.meip),
    .mtip_i       (bus.mtip),
    .irq_pend_o   (irq_pend),
    .intr_cause_o (irq_cause)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      exc_cause_q  <= 4'd0;
      intr_cause_q <= 4'd0;
      trap_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      exc_cause_q  <= exc_cause_d;
      intr_cause_q <= intr_cause_d;
      trap_pc_q    <= trap_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    exc_cause_d  = exc_cause_q;
    intr_cause_d = intr_cause_q;
    trap_pc_d    = trap_pc_q;
    exc_hit      = bus.commit_valid & bus.excep_req;

    unique case (state_q)
      IDLE: begin
        if (exc_hit) begin
          state_d     = TAKE_EXC;
          exc_cause_d = bus.excep_code;
          trap_pc_d   = bus.commit_pc;
        end else if (irq_pend) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else if (bus.commit_valid && bus.mret_req) begin
          state_d = RET;
        end
      end
      DRAIN: begin
        cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
        if (!irq_pend && !exc_hit) begin
          state_d = IDLE;
        end else if (exc_hit) begin
          state_d     = TAKE_EXC;
          exc_cause_d = bus.excep_code;
          trap_pc_d   = bus.commit_pc;
        end else if (bus.commit_valid) begin
          // The boundary instruction is flushed and becomes mepc.
          state_d      = TAKE_INT;
          intr_cause_d = irq_cause;
          trap_pc_d    = bus.commit_pc;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = TAKE_INT;
          intr_cause_d = irq_cause;
          trap_pc_d    = bus.fetch_pc;
        end
      end
      TAKE_INT, TAKE_EXC, RET: state_d = RECOVER;
      RECOVER:                 state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.intr_en         = 1'b0;
    bus.excep_en        = 1'b0;
    bus.mret            = 1'b0;
    bus.stall           = 1'b0;
    bus.flush           = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_sel    = 1'b0;
    bus.busy            = (state_q != IDLE);
    bus.intr_cause      = intr_cause_q;
    bus.exception_cause = exc_cause_q;
    bus.trap_pc         = trap_pc_q;

    unique case (state_q)
      DRAIN: bus.stall = 1'b1;
      TAKE_INT: begin
        bus.intr_en  = 1'b1;
        bus.stall    = 1'b1;
        bus.flush    = 1'b1;
        bus.redirect = 1'b1;
      end
      TAKE_EXC: begin
        bus.excep_en = 1'b1;
        bus.stall    = 1'b1;
        bus.flush    = 1'b1;
        bus.redirect = 1'b1;
      end
      RET: begin
        bus.mret         = 1'b1;
        bus.stall        = 1'b1;
        bus.flush        = 1'b1;
        bus.redirect     = 1'b1;
        bus.redirect_sel = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized and directed bench for trap_sequencer, checked per cycle against
// a transaction-level reference model through an expected-output queue.
module tb_trap_sequencer;
  import trap_pkg::*;

  localparam int DRAIN_MAX = 8;
  localparam int XLEN      = 32;
  localparam int W         = 44;

  localparam int K_IDLE = 0;
  localparam int K_DRAIN = 1;
  localparam int K_INT = 2;
  localparam int K_EXC = 3;
  localparam int K_RET = 4;
  localparam int K_REC = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trap_sequencer_if #(.XLEN(XLEN)) bus ();
  trap_state_e dbg_state;

  trap_sequencer #(.DRAIN_MAX(DRAIN_MAX), .XLEN(XLEN)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] sched_q[$];
  bit m_drain;
  int m_age;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs packed as {intr_en,excep_en,mret,flush,redirect,redirect_sel,stall,busy, cause, pc}
  function automatic logic [W-1:0] mk(input int kind, input logic [3:0] cause, input logic [31:0] pc);
    logic [7:0] f;
    case (kind)
      K_DRAIN: f = 8'b0000_0011;
      K_INT:   f = 8'b1001_1011;
      K_EXC:   f = 8'b0101_1011;
      K_RET:   f = 8'b0011_1111;
      K_REC:   f = 8'b0000_0001;
      default: f = 8'b0000_0000;
    endcase
    return {f, cause, pc};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] take(input int kind, input logic [3:0] cause, input logic [31:0] pc);
    m_drain = 1'b0;
    sched_q.push_back(mk(K_REC, 4'd0, 32'd0));
    sched_q.push_back(mk(K_IDLE, 4'd0, 32'd0));
    return mk(kind, cause, pc);
  endfunction

  // Given this cycle's inputs, predict the outputs of the next cycle.
  task automatic model_step();
    logic [W-1:0] nxt;
    bit pend, exc, cv;
    logic [3:0] ic;
    cv   = bus.commit_valid;
    pend = bus.mie && ((bus.meip && bus.meie) || (bus.mtip && bus.mtie));
    ic   = (bus.meip && bus.meie) ? 4'd11 : 4'd7;
    exc  = cv && bus.excep_req;
    if (sched_q.size() > 0) begin
      nxt = sched_q.pop_front();
    end else if (m_drain) begin
      if (!pend && !exc) begin
        m_drain = 1'b0;
        nxt = mk(K_IDLE, 4'd0, 32'd0);
      end else if (exc) nxt = take(K_EXC, bus.excep_code, bus.commit_pc);
      else if (cv) nxt = take(K_INT, ic, bus.commit_pc);
      else if (m_age == DRAIN_MAX - 1) nxt = take(K_INT, ic, bus.fetch_pc);
      else begin
        m_age++;
        nxt = mk(K_DRAIN, 4'd0, 32'd0);
      end
    end else begin
      if (exc) nxt = take(K_EXC, bus.excep_code, bus.commit_pc);
      else if (pend) begin
        m_drain = 1'b1;
        m_age = 0;
        nxt = mk(K_DRAIN, 4'd0, 32'd0);
      end else if (cv && bus.mret_req) nxt = take(K_RET, 4'd0, 32'd0);
      else nxt = mk(K_IDLE, 4'd0, 32'd0);
    end
    exp_q.push_back(nxt);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] mon_e;
  logic [7:0]   mon_f;
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        check("exp_q_underflow", 64'(1), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        mon_f = {bus.intr_en, bus.excep_en, bus.mret, bus.flush,
                 bus.redirect, bus.redirect_sel, bus.stall, bus.busy};
        check("ctrl_flags", 64'(mon_f), 64'(mon_e[43:36]));
        if (mon_e[43]) begin
          check("intr_cause", 64'(bus.intr_cause), 64'(mon_e[35:32]));
          check("trap_pc_int", 64'(bus.trap_pc), 64'(mon_e[31:0]));
        end
        if (mon_e[42]) begin
          check("exception_cause", 64'(bus.exception_cause), 64'(mon_e[35:32]));
          check("trap_pc_exc", 64'(bus.trap_pc), 64'(mon_e[31:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic irq(input bit a, input bit b, input bit c, input bit d, input bit e);
    bus.mie = a; bus.meie = b; bus.mtie = c; bus.meip = d; bus.mtip = e;
  endtask

  task automatic drive(input bit cv, input logic [31:0] pc, input bit exc,
                       input logic [3:0] code, input bit mr);
    bus.commit_valid = cv; bus.commit_pc = pc; bus.excep_req = exc;
    bus.excep_code = code; bus.mret_req = mr;
  endtask

  task automatic restart();
    exp_q.delete();
    sched_q.delete();
    m_drain = 1'b0;
    m_age = 0;
    exp_q.push_back(mk(K_IDLE, 4'd0, 32'd0));
    mon_en = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, 64'({bus.intr_en, bus.excep_en, bus.mret, bus.stall,
                                  bus.flush, bus.redirect, bus.redirect_sel, bus.busy}), 64'(0));
    check({tag, "_causes"}, 64'({bus.intr_cause, bus.exception_cause}), 64'(0));
    check({tag, "_trap_pc"}, 64'(bus.trap_pc), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    irq(0, 0, 0, 0, 0);
    drive(0, 32'd0, 0, 4'd0, 0);
    bus.fetch_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    restart();

    // Timer IRQ, boundary found two cycles into drain
    irq(1, 0, 1, 0, 1);
    tick(); tick();
    drive(1, 32'h100, 0, 4'd0, 0);
    tick();
    irq(0, 0, 0, 0, 0);
    drive(0, 32'd0, 0, 4'd0, 0);
    repeat (3) tick();

    // Both pending: external wins
    irq(1, 1, 1, 1, 1);
    tick();
    drive(1, 32'h180, 0, 4'd0, 0);
    tick();
    drive(0, 32'd0, 0, 4'd0, 0);
    irq(0, 0, 0, 0, 0);
    repeat (3) tick();

    // Exception during drain beats the pending interrupt
    irq(1, 1, 1, 1, 1);
    tick(); tick();
    drive(1, 32'h204, 1, 4'd2, 0);
    tick();
    drive(0, 32'd0, 0, 4'd0, 0);
    irq(0, 0, 0, 0, 0);
    repeat (3) tick();

    // Drain timeout uses fetch_pc
    irq(1, 1, 0, 1, 0);
    bus.fetch_pc = 32'h3C0;
    repeat (DRAIN_MAX + 3) tick();
    irq(0, 0, 0, 0, 0);
    repeat (3) tick();

    // Drain abort: external drops after three drain cycles
    irq(1, 1, 0, 1, 0);
    repeat (4) tick();
    bus.meip = 1'b0;
    repeat (3) tick();

    // mret, then exception plus mret on the same commit
    drive(1, 32'h440, 0, 4'd0, 1);
    tick();
    drive(0, 32'd0, 0, 4'd0, 0);
    repeat (3) tick();
    drive(1, 32'h480, 1, 4'd5, 1);
    tick();
    drive(0, 32'd0, 0, 4'd0, 0);
    repeat (3) tick();

    // Reset in the middle of a drain
    irq(1, 0, 1, 0, 1);
    tick(); tick();
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_drain");
    check("reset_mid_drain_state", 64'(dbg_state), 64'(IDLE));
    irq(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    restart();
    repeat (3) tick();

    // Randomized traffic with varying commit density
    for (int seg = 0; seg < 40; seg++) begin
      int cv_pct;
      cv_pct = (seg % 3 == 0) ? 5 : ((seg % 3 == 1) ? 40 : 85);
      for (int c = 0; c < 20; c++) begin
        if ($urandom_range(0, 5) == 0) begin
          bus.mie  = ($urandom_range(0, 9) < 8);
          bus.meie = 1'($urandom_range(0, 1));
          bus.mtie = 1'($urandom_range(0, 1));
          bus.meip = ($urandom_range(0, 9) < 3);
          bus.mtip = ($urandom_range(0, 9) < 3);
        end
        bus.commit_valid = ($urandom_range(0, 99) < cv_pct);
        bus.commit_pc    = $urandom() & 32'hFFFF_FFFC;
        bus.fetch_pc     = $urandom() & 32'hFFFF_FFFC;
        bus.excep_req    = ($urandom_range(0, 9) == 0);
        bus.excep_code   = 4'($urandom_range(0, 15));
        bus.mret_req     = ($urandom_range(0, 9) == 0);
        tick();
      end
    end

    irq(0, 0, 0, 0, 0);
    drive(0, 32'd0, 0, 4'd0, 0);
    repeat (4) tick();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
